// File: rtl/free_list_head_checkpoint_if.sv
// Purpose: bundles the rename-side allocation, execute-side resolution and
//          status signals of the free-list head checkpoint store.
// Signals:
//   recoverFlag_i    full pipeline flush
//   stall_i          rename stalled
//   allocReq_i       rename group requests a checkpoint
//   headSnap_i       free-list head to snapshot
//   ctrlTag_o        tag granted to the allocating group
//   cpFull_o         no free checkpoint entry
//   ctrlVerified_i   a control instruction resolved
//   ctrlTag_i        tag of the resolving instruction
//   flagRecoverEX_i  resolving instruction mispredicted
//   freeListHeadCp_o snapshot stored for ctrlTag_i (combinational)
//   cpCount_o        number of live entries
// Modports: master = rename/execute side, slave = checkpoint store.
`ifndef SIZE_FREE_LIST_LOG
`define SIZE_FREE_LIST_LOG 7
`endif

interface free_list_head_checkpoint_if #(
  parameter int unsigned CP_LOG = 3,
  parameter int unsigned HEAD_W = `SIZE_FREE_LIST_LOG
);
  logic              recoverFlag_i;
  logic              stall_i;
  logic              allocReq_i;
  logic [HEAD_W-1:0] headSnap_i;
  logic [CP_LOG-1:0] ctrlTag_o;
  logic              cpFull_o;
  logic              ctrlVerified_i;
  logic [CP_LOG-1:0] ctrlTag_i;
  logic              flagRecoverEX_i;
  logic [HEAD_W-1:0] freeListHeadCp_o;
  logic [CP_LOG:0]   cpCount_o;

  modport master (
    output recoverFlag_i, stall_i, allocReq_i, headSnap_i,
    output ctrlVerified_i, ctrlTag_i, flagRecoverEX_i,
    input  ctrlTag_o, cpFull_o, freeListHeadCp_o, cpCount_o
  );

  modport slave (
    input  recoverFlag_i, stall_i, allocReq_i, headSnap_i,
    input  ctrlVerified_i, ctrlTag_i, flagRecoverEX_i,
    output ctrlTag_o, cpFull_o, freeListHeadCp_o, cpCount_o
  );
endinterface

// File: rtl/free_list_head_checkpoint.sv
// Purpose: circular FIFO of branch checkpoints holding speculative free-list
//          head snapshots. Allocated at the tail by rename, released in order
//          from the head once resolved, truncated back to the resolving tag
//          on a mispredict, whose snapshot is returned in the same cycle.
// Ports:
//   clk    clock, all state updates on posedge
//   reset  synchronous, active-high
//   bus    free_list_head_checkpoint_if.slave (alloc / resolve / status)
// Build option:
//   CKPT_FULL_BYPASS_EN  when defined, a full store whose head releases this
//                        cycle accepts an allocation in the same cycle.
`ifndef SIZE_FREE_LIST_LOG
`define SIZE_FREE_LIST_LOG 7
`endif

module free_list_head_checkpoint #(
  parameter int unsigned CP_DEPTH = 8,
  parameter int unsigned CP_LOG   = 3,
  parameter int unsigned HEAD_W   = `SIZE_FREE_LIST_LOG
) (
  input  logic                          clk,
  input  logic                          reset,
  free_list_head_checkpoint_if.slave    bus
);

  logic [HEAD_W-1:0]   r_snap [CP_DEPTH];
  logic [CP_DEPTH-1:0] r_valid;
  logic [CP_DEPTH-1:0] r_resolved;
  logic [CP_LOG-1:0]   r_head;
  logic [CP_LOG-1:0]   r_tail;
  logic [CP_LOG:0]     r_cnt;

  logic [CP_DEPTH-1:0] w_valid_nxt;
  logic [CP_DEPTH-1:0] w_resolved_nxt;
  logic [CP_LOG-1:0]   w_head_nxt;
  logic [CP_LOG-1:0]   w_tail_nxt;
  logic [CP_LOG:0]     w_cnt_nxt;
  logic [CP_LOG-1:0]   w_mp_span;
  logic [CP_LOG-1:0]   w_tag_off;

  logic w_tag_valid;
  logic w_mispredict;
  logic w_resolve_ok;
  logic w_head_ready;
  logic w_full;
  logic w_full_c;
  logic w_release;
  logic w_alloc;

  // Event decode; a tag that is not live is ignored entirely.
  assign w_tag_valid  = r_valid[bus.ctrlTag_i];
  assign w_mispredict = bus.ctrlVerified_i &  bus.flagRecoverEX_i & w_tag_valid;
  assign w_resolve_ok = bus.ctrlVerified_i & ~bus.flagRecoverEX_i & w_tag_valid;
  assign w_head_ready = r_valid[r_head] & r_resolved[r_head];
  assign w_full       = (r_cnt == (CP_LOG+1)'(CP_DEPTH));

`ifdef CKPT_FULL_BYPASS_EN
  // The slot freed by this cycle's head release can be refilled immediately.
  assign w_full_c = w_full & ~w_head_ready;
`else
  assign w_full_c = w_full;
`endif

  // A mispredicting head entry is kept: it becomes the new youngest entry.
  assign w_release = w_head_ready & ~(w_mispredict & (r_head == bus.ctrlTag_i));
  assign w_alloc   = bus.allocReq_i & ~bus.stall_i & ~w_full_c & ~w_mispredict
                   & ~bus.recoverFlag_i & ~reset;

  assign w_tag_off = CP_LOG'(bus.ctrlTag_i - r_head);
  assign w_mp_span = CP_LOG'(bus.ctrlTag_i + CP_LOG'(1) - w_head_nxt);

  // Next-state: release, then resolve, then mispredict truncation or alloc.
  always_comb begin
    w_valid_nxt    = r_valid;
    w_resolved_nxt = r_resolved;
    w_tail_nxt     = r_tail;
    w_head_nxt     = r_head + CP_LOG'(w_release);
    w_cnt_nxt      = r_cnt;

    if (w_release) begin
      w_valid_nxt[r_head] = 1'b0;
    end

    if (w_resolve_ok || w_mispredict) begin
      w_resolved_nxt[bus.ctrlTag_i] = 1'b1;
    end

    if (w_mispredict) begin
      // Drop every entry younger than the resolving tag (age = offset from head).
      for (int unsigned i = 0; i < CP_DEPTH; i++) begin
        if (CP_LOG'(CP_LOG'(i) - r_head) > w_tag_off) begin
          w_valid_nxt[i] = 1'b0;
        end
      end
      w_tail_nxt = bus.ctrlTag_i + CP_LOG'(1);
      // A zero span can only mean every slot up to the tag is still live.
      w_cnt_nxt  = (w_mp_span == '0) ? (CP_LOG+1)'(CP_DEPTH) : {1'b0, w_mp_span};
    end else begin
      if (w_alloc) begin
        w_valid_nxt[r_tail]    = 1'b1;
        w_resolved_nxt[r_tail] = 1'b0;
        w_tail_nxt             = r_tail + CP_LOG'(1);
      end
      w_cnt_nxt = r_cnt + (CP_LOG+1)'(w_alloc) - (CP_LOG+1)'(w_release);
    end
  end

  // Control state; a commit-time flush behaves like reset.
  always_ff @(posedge clk) begin
    if (reset || bus.recoverFlag_i) begin
      r_valid    <= '0;
      r_resolved <= '0;
      r_head     <= '0;
      r_tail     <= '0;
      r_cnt      <= '0;
    end else begin
      r_valid    <= w_valid_nxt;
      r_resolved <= w_resolved_nxt;
      r_head     <= w_head_nxt;
      r_tail     <= w_tail_nxt;
      r_cnt      <= w_cnt_nxt;
    end
  end

  // Snapshot storage is never cleared; it is only meaningful while valid.
  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_snap[r_tail] <= bus.headSnap_i;
    end
  end

  assign bus.ctrlTag_o        = r_tail;
  assign bus.cpFull_o         = w_full_c;
  assign bus.cpCount_o        = r_cnt;
  assign bus.freeListHeadCp_o = r_snap[bus.ctrlTag_i];

endmodule

// File: tb/tb_free_list_head_checkpoint.sv
`ifndef SIZE_FREE_LIST_LOG
`define SIZE_FREE_LIST_LOG 7
`endif

module tb_free_list_head_checkpoint;
  localparam int unsigned HW    = `SIZE_FREE_LIST_LOG;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  free_list_head_checkpoint_if #(.CP_LOG(3), .HEAD_W(HW)) bus ();

  free_list_head_checkpoint #(.CP_DEPTH(DEPTH), .CP_LOG(3), .HEAD_W(HW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: live entries as an ordered queue of resolved flags,
  // oldest first, plus the index of the oldest slot.
  int          m_head = 0;
  bit          m_res[$];
  logic [HW-1:0] m_snap [DEPTH];
  bit          m_snap_ok [DEPTH];

  function automatic int m_tail();
    return (m_head + m_res.size()) % DEPTH;
  endfunction

  function automatic bit m_full();
    bit f;
    f = (m_res.size() == DEPTH);
`ifdef CKPT_FULL_BYPASS_EN
    if (f && m_res[0]) f = 1'b0;
`endif
    return f;
  endfunction

  function automatic void model_step();
    int off, otail;
    bit live, mp, alloc, rel;
    if (reset || bus.recoverFlag_i) begin
      m_res.delete();
      m_head = 0;
      return;
    end
    off   = (int'(bus.ctrlTag_i) - m_head + DEPTH) % DEPTH;
    live  = off < m_res.size();
    mp    = bus.ctrlVerified_i && bus.flagRecoverEX_i && live;
    alloc = bus.allocReq_i && !bus.stall_i && !m_full() && !mp;
    rel   = (m_res.size() > 0) && m_res[0] && !(mp && off == 0);
    otail = m_tail();
    if (bus.ctrlVerified_i && live) m_res[off] = 1'b1;
    if (mp) while (m_res.size() > off + 1) void'(m_res.pop_back());
    if (rel) begin
      void'(m_res.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    if (alloc) begin
      m_res.push_back(1'b0);
      m_snap[otail]    = bus.headSnap_i;
      m_snap_ok[otail] = 1'b1;
    end
  endfunction

  task automatic set_in(input logic rv, input logic st, input logic ar,
                        input logic [HW-1:0] hs, input logic vf,
                        input logic [2:0] tg, input logic fe);
    bus.recoverFlag_i   = rv;
    bus.stall_i         = st;
    bus.allocReq_i      = ar;
    bus.headSnap_i      = hs;
    bus.ctrlVerified_i  = vf;
    bus.ctrlTag_i       = tg;
    bus.flagRecoverEX_i = fe;
    #1;
  endtask

  task automatic idle();
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    reset = 1'b0;
  endtask

  task automatic alloc_n(input int n, input int base, input int step);
    for (int i = 0; i < n; i++) begin
      set_in(1'b0, 1'b0, 1'b1, HW'(base + step * i), 1'b0, 3'd0, 1'b0);
      tick();
    end
    idle();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus.cpCount_o !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.cpCount_o); end
    total++; if (bus.ctrlTag_o !== 3'd0) begin bad++; $display("FAIL reset_tag got=%0d want=0", bus.ctrlTag_o); end
    total++; if (bus.cpFull_o !== 1'b0) begin bad++; $display("FAIL reset_full got=%0b want=0", bus.cpFull_o); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b0, 1'b1, HW'(3 + 4 * i), 1'b0, 3'd0, 1'b0);
      total++; if (bus.ctrlTag_o !== 3'(i)) begin bad++; $display("FAIL fill_tag%0d got=%0d want=%0d", i, bus.ctrlTag_o, i); end
      tick();
    end
    idle();
    total++; if (bus.cpFull_o !== 1'b1) begin bad++; $display("FAIL fill_full got=%0b want=1", bus.cpFull_o); end
    total++; if (bus.cpCount_o !== 4'd8) begin bad++; $display("FAIL fill_count got=%0d want=8", bus.cpCount_o); end
    // Ninth request while full is ignored.
    set_in(1'b0, 1'b0, 1'b1, HW'(99), 1'b0, 3'd0, 1'b0);
    tick();
    idle();
    total++; if (bus.ctrlTag_o !== 3'd0) begin bad++; $display("FAIL full_tail got=%0d want=0", bus.ctrlTag_o); end
    total++; if (bus.cpCount_o !== 4'd8) begin bad++; $display("FAIL full_count got=%0d want=8", bus.cpCount_o); end
    for (int i = 0; i < 8; i++) begin
      set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, 3'(i), 1'b0);
      total++; if (bus.freeListHeadCp_o !== HW'(3 + 4 * i)) begin bad++; $display("FAIL full_snap%0d got=%0d want=%0d", i, bus.freeListHeadCp_o, 3 + 4 * i); end
    end
    idle();
  endtask

  task automatic test_resolve();
    do_reset();
    alloc_n(5, 40, 1);
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, 3'd0, 1'b0);
    tick();
    idle();
    total++; if (bus.cpCount_o !== 4'd5) begin bad++; $display("FAIL resolve_same_cycle got=%0d want=5", bus.cpCount_o); end
    tick();
    total++; if (bus.cpCount_o !== 4'd4) begin bad++; $display("FAIL resolve_release got=%0d want=4", bus.cpCount_o); end
    total++; if (bus.ctrlTag_o !== 3'd5) begin bad++; $display("FAIL resolve_tail got=%0d want=5", bus.ctrlTag_o); end
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc_n(6, 10, 1);
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, 3'd2, 1'b1);
    total++; if (bus.freeListHeadCp_o !== HW'(12)) begin bad++; $display("FAIL mp_snap got=%0d want=12", bus.freeListHeadCp_o); end
    tick();
    idle();
    total++; if (bus.cpCount_o !== 4'd3) begin bad++; $display("FAIL mp_count got=%0d want=3", bus.cpCount_o); end
    total++; if (bus.ctrlTag_o !== 3'd3) begin bad++; $display("FAIL mp_tail got=%0d want=3", bus.ctrlTag_o); end
    // Mispredict on the youngest slot of a full store keeps all 8 entries.
    do_reset();
    alloc_n(8, 1, 2);
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, 3'd7, 1'b1);
    total++; if (bus.freeListHeadCp_o !== HW'(15)) begin bad++; $display("FAIL mp_last_snap got=%0d want=15", bus.freeListHeadCp_o); end
    tick();
    idle();
    total++; if (bus.cpCount_o !== 4'd8) begin bad++; $display("FAIL mp_last_count got=%0d want=8", bus.cpCount_o); end
    total++; if (bus.ctrlTag_o !== 3'd0) begin bad++; $display("FAIL mp_last_tail got=%0d want=0", bus.ctrlTag_o); end
  endtask

  task automatic test_mp_alloc();
    do_reset();
    alloc_n(4, 30, 1);
    set_in(1'b0, 1'b0, 1'b1, HW'(77), 1'b1, 3'd1, 1'b1);
    tick();
    idle();
    total++; if (bus.cpCount_o !== 4'd2) begin bad++; $display("FAIL mpa_count got=%0d want=2", bus.cpCount_o); end
    total++; if (bus.ctrlTag_o !== 3'd2) begin bad++; $display("FAIL mpa_tail got=%0d want=2", bus.ctrlTag_o); end
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b0, 3'd2, 1'b0);
    total++; if (bus.freeListHeadCp_o !== HW'(32)) begin bad++; $display("FAIL mpa_snap got=%0d want=32", bus.freeListHeadCp_o); end
    idle();
  endtask

  task automatic test_recover();
    do_reset();
    alloc_n(5, 60, 1);
    set_in(1'b1, 1'b0, 1'b1, HW'(5), 1'b1, 3'd1, 1'b1);
    tick();
    idle();
    total++; if (bus.cpCount_o !== 4'd0) begin bad++; $display("FAIL rec_count got=%0d want=0", bus.cpCount_o); end
    total++; if (bus.ctrlTag_o !== 3'd0) begin bad++; $display("FAIL rec_tail got=%0d want=0", bus.ctrlTag_o); end
    total++; if (bus.cpFull_o !== 1'b0) begin bad++; $display("FAIL rec_full got=%0b want=0", bus.cpFull_o); end
  endtask

  task automatic test_full_bypass();
    do_reset();
    alloc_n(8, 20, 1);
    set_in(1'b0, 1'b0, 1'b0, '0, 1'b1, 3'd0, 1'b0);
    tick();
    set_in(1'b0, 1'b0, 1'b1, HW'(55), 1'b0, 3'd0, 1'b0);
`ifdef CKPT_FULL_BYPASS_EN
    total++; if (bus.cpFull_o !== 1'b0) begin bad++; $display("FAIL byp_full got=%0b want=0", bus.cpFull_o); end
    tick();
    idle();
    total++; if (bus.cpCount_o !== 4'd8) begin bad++; $display("FAIL byp_count got=%0d want=8", bus.cpCount_o); end
    total++; if (bus.ctrlTag_o !== 3'd1) begin bad++; $display("FAIL byp_tail got=%0d want=1", bus.ctrlTag_o); end
    total++; if (bus.freeListHeadCp_o !== HW'(55)) begin bad++; $display("FAIL byp_snap got=%0d want=55", bus.freeListHeadCp_o); end
`else
    total++; if (bus.cpFull_o !== 1'b1) begin bad++; $display("FAIL byp_full got=%0b want=1", bus.cpFull_o); end
    tick();
    idle();
    total++; if (bus.cpCount_o !== 4'd7) begin bad++; $display("FAIL byp_count got=%0d want=7", bus.cpCount_o); end
    total++; if (bus.ctrlTag_o !== 3'd0) begin bad++; $display("FAIL byp_tail got=%0d want=0", bus.ctrlTag_o); end
    total++; if (bus.freeListHeadCp_o !== HW'(20)) begin bad++; $display("FAIL byp_snap got=%0d want=20", bus.freeListHeadCp_o); end
`endif
  endtask

  task automatic test_random();
    logic [2:0] tg;
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if (m_res.size() > 0 && ($urandom % 10) < 7)
        tg = 3'((m_head + int'($urandom % m_res.size())) % DEPTH);
      else
        tg = 3'($urandom);
      set_in(($urandom % 250) == 0, ($urandom % 8) == 0, ($urandom % 3) != 0,
             HW'($urandom), ($urandom % 3) == 0, tg, ($urandom % 6) == 0);
      total++; if (bus.cpCount_o !== 4'(m_res.size())) begin bad++; $display("FAIL rnd_count n=%0d got=%0d want=%0d", n, bus.cpCount_o, m_res.size()); end
      total++; if (bus.ctrlTag_o !== 3'(m_tail())) begin bad++; $display("FAIL rnd_tail n=%0d got=%0d want=%0d", n, bus.ctrlTag_o, m_tail()); end
      total++; if (bus.cpFull_o !== m_full()) begin bad++; $display("FAIL rnd_full n=%0d got=%0b want=%0b", n, bus.cpFull_o, m_full()); end
      if (m_snap_ok[tg]) begin
        total++; if (bus.freeListHeadCp_o !== m_snap[tg]) begin bad++; $display("FAIL rnd_snap n=%0d tag=%0d got=%0d want=%0d", n, tg, bus.freeListHeadCp_o, m_snap[tg]); end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    reset = 1'b1;
    idle();
    test_reset();
    test_fill();
    test_resolve();
    test_mispredict();
    test_mp_alloc();
    test_recover();
    test_full_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
